// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions used by the receive path (and the future mouse
// receiver): frame geometry and the frame-decoder state encoding.
package ps2_pkg;

  localparam int PS2_FRAME_BITS = 11;  // start + 8 data + parity + stop
  localparam int PS2_DATA_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

endpackage

// File: rtl/ps2_sync_edge.sv
// PS/2 line synchroniser and falling-edge detector.
// Both raw lines go through identical SYNC_STAGES flop chains so clock and
// data keep their relative timing; a falling edge of the synchronised clock
// produces a one-cycle 'fall' with the matching data bit on 'data_s'.
// Ports:
//   clk      in  system clock
//   clrn     in  async active-low reset (lines reset to the idle-high level)
//   ps2_clk  in  raw PS/2 clock line
//   ps2_data in  raw PS/2 data line
//   fall     out one-cycle strobe: synchronised ps2_clk went 1 -> 0
//   data_s   out synchronised ps2_data, valid to sample when fall=1
module ps2_sync_edge #(
  parameter int SYNC_STAGES = 3
) (
  input  logic clk,
  input  logic clrn,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data_s
);

  // Bit 0 is the first (metastable-facing) stage, MSB is the last stage.
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  // Last-stage clock value from the previous cycle, for edge detection.
  logic                   clk_prev;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall   = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign data_s = dat_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver feeding the keyboard byte FIFO.
// Deserialises start / 8 data (LSB first) / odd parity / stop frames clocked
// by falling ps2_clk edges, writes good bytes to the FIFO write port and
// pulses one error flag for each rejected frame.
// Ports:
//   clk        in  system clock
//   clrn       in  async active-low reset
//   ps2_clk    in  raw PS/2 clock line
//   ps2_data   in  raw PS/2 data line
//   wrfull     in  FIFO full; checked when a good byte is ready
//   data       out last good byte (held between writes)
//   wrreq      out one-cycle FIFO write strobe, coincident with new data
//   parity_err out one-cycle pulse: odd parity failed
//   frame_err  out one-cycle pulse: stop bit low or inter-edge timeout
//   overflow   out one-cycle pulse: good byte dropped, FIFO full
//   err_count  out saturating count of all error pulses
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int ERR_CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic                 ps2_clk,
  input  logic                 ps2_data,
  input  logic                 wrfull,
  output logic [7:0]           data,
  output logic                 wrreq,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overflow,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    LAST_BIT = 3'(PS2_DATA_BITS - 1);

  logic fall, data_s;

  ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .clrn     (clrn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .fall     (fall),
    .data_s   (data_s)
  );

  state_t                   state, state_nxt;
  logic [2:0]               bit_cnt;
  logic [TW-1:0]            timer;
  logic [PS2_DATA_BITS-1:0] shreg;
  logic                     par_bit;

  // Frame-level events decided combinationally, registered below.
  logic tmo_hit, eval;
  logic good_nxt, par_err_nxt, frm_err_nxt, ovf_nxt, any_err;

  // Timeout only counts inside a frame; a coincident fall takes priority.
  assign tmo_hit = (state != IDLE) && !fall && (timer == TMO_LAST);

  always_comb begin
    state_nxt = state;
    eval      = 1'b0;
    case (state)
      IDLE:   if (fall && !data_s) state_nxt = DATA;  // high "start" = glitch
      DATA:   if (fall) begin
                if (bit_cnt == LAST_BIT) state_nxt = PARITY;
              end else if (tmo_hit) state_nxt = IDLE;
      PARITY: if (fall) state_nxt = STOP;
              else if (tmo_hit) state_nxt = IDLE;
      STOP:   if (fall) begin
                state_nxt = IDLE;
                eval      = 1'b1;
              end else if (tmo_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stop-bit evaluation priority: framing, then parity, then FIFO space.
  // Odd parity means data bits plus parity bit XOR to 1.
  always_comb begin
    frm_err_nxt = tmo_hit;
    par_err_nxt = 1'b0;
    ovf_nxt     = 1'b0;
    good_nxt    = 1'b0;
    if (eval) begin
      if (!data_s)                    frm_err_nxt = 1'b1;
      else if (!(^{shreg, par_bit}))  par_err_nxt = 1'b1;
      else if (wrfull)                ovf_nxt     = 1'b1;
      else                            good_nxt    = 1'b1;
    end
  end

  assign any_err = frm_err_nxt | par_err_nxt | ovf_nxt;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Deserialiser and inter-edge timer.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bit_cnt <= '0;
      timer   <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      timer <= (state == IDLE || fall) ? '0 : timer + 1'b1;
      if (fall) begin
        case (state)
          IDLE: bit_cnt <= '0;
          DATA: begin
            shreg   <= {data_s, shreg[PS2_DATA_BITS-1:1]};  // LSB arrives first
            bit_cnt <= bit_cnt + 1'b1;
          end
          PARITY: par_bit <= data_s;
          default: ;
        endcase
      end
    end
  end

  // Registered outputs: one-cycle result pulses and the saturating counter.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      data       <= '0;
      wrreq      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
      err_count  <= '0;
    end else begin
      wrreq      <= good_nxt;
      parity_err <= par_err_nxt;
      frame_err  <= frm_err_nxt;
      overflow   <= ovf_nxt;
      if (good_nxt) data <= shreg;
      if (any_err && (err_count != '1)) err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed bench for ps2_rx_frame. The PS/2 clock is scaled down to a few
// system clocks per half period so the shortened timeout (100 cycles) and the
// saturation run stay short. Expected bytes and parity bits are hand-computed.
module tb_ps2_rx_frame;
  import ps2_pkg::*;

  localparam int HALF = 8;    // system clocks per PS/2 half period
  localparam int TMO  = 100;
  localparam int SYNC = 3;

  logic       clk = 1'b0, clrn = 1'b0;
  logic       ps2_clk = 1'b1, ps2_data = 1'b1, wrfull = 1'b0;
  logic [7:0] data, err_count;
  logic       wrreq, parity_err, frame_err, overflow;

  ps2_rx_frame #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO), .ERR_CNT_W(8)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .wrfull(wrfull), .data(data), .wrreq(wrreq), .parity_err(parity_err),
    .frame_err(frame_err), .overflow(overflow), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Pulse monitor: counts asserted cycles of each output and logs written bytes.
  int         n_wr = 0, n_par = 0, n_frm = 0, n_ovf = 0, n_multi = 0;
  logic [7:0] wq[$];

  always @(negedge clk) begin
    if (clrn) begin
      if (wrreq) begin n_wr++; wq.push_back(data); end
      if (parity_err) n_par++;
      if (frame_err)  n_frm++;
      if (overflow)   n_ovf++;
      if ((32'(wrreq) + 32'(parity_err) + 32'(frame_err) + 32'(overflow)) > 1) n_multi++;
    end
  end

  int b_wr, b_par, b_frm, b_ovf;
  task automatic snap();
    b_wr = n_wr; b_par = n_par; b_frm = n_frm; b_ovf = n_ovf;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    cyc(HALF);
    ps2_clk = 1'b0;
    cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    send_bit(1'b0);
    for (int i = 0; i < PS2_DATA_BITS; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stp);
  endtask

  int first;
  int qb;

  initial begin
    cyc(3);
    // Reset state
    chk("rst_data", data, 8'h00);
    chk("rst_cnt", err_count, 8'h00);
    chk("rst_pulses", {wrreq, parity_err, frame_err, overflow}, 4'b0000);
    clrn = 1'b1;
    cyc(5);

    // Good 0x1C (3 ones -> parity 0)
    snap();
    send_frame(8'h1C, 1'b0, 1'b1); cyc(4);
    chk("good_wr", n_wr - b_wr, 1);
    chk("good_data", data, 8'h1C);
    chk("good_errs", (n_par - b_par) + (n_frm - b_frm) + (n_ovf - b_ovf), 0);
    chk("good_cnt", err_count, 0);

    // Back-to-back 0xF0 (parity 1) and 0x1C, no gap
    snap(); qb = wq.size();
    send_frame(8'hF0, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1); cyc(4);
    chk("b2b_wr", n_wr - b_wr, 2);
    chk("b2b_first", (wq.size() > qb) ? 32'(wq[qb]) : 32'hFFFF, 8'hF0);
    chk("b2b_second", (wq.size() > qb + 1) ? 32'(wq[qb+1]) : 32'hFFFF, 8'h1C);

    // Parity error, then stop-bit error
    snap();
    send_frame(8'h1C, 1'b1, 1'b1); cyc(4);
    chk("par_pulse", n_par - b_par, 1);
    chk("par_nowr", n_wr - b_wr, 0);
    chk("par_cnt", err_count, 1);
    chk("par_data", data, 8'h1C);
    snap();
    send_frame(8'h1C, 1'b0, 1'b0); cyc(4);
    chk("stop_pulse", n_frm - b_frm, 1);
    chk("stop_cnt", err_count, 2);

    // Stall after 5 bits (start + 4 data). The 5th fall is driven by hand;
    // frame_err is expected 100 cycles after the fall reaches the FSM, which is
    // SYNC+1 posedges after the line is driven.
    snap();
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    ps2_data = 1'b1; cyc(HALF);
    ps2_clk = 1'b0;
    first = 0;
    for (int n = 1; n <= 3 * TMO; n++) begin
      @(negedge clk);
      if (n == HALF) ps2_clk = 1'b1;
      if (frame_err && first == 0) first = n;
    end
    chk("tmo_cycle", first, TMO + SYNC + 1);
    chk("tmo_pulse", n_frm - b_frm, 1);
    chk("tmo_nowr", n_wr - b_wr, 0);
    chk("tmo_cnt", err_count, 3);
    snap();
    send_frame(8'hE0, 1'b0, 1'b1); cyc(4);
    chk("post_tmo_wr", n_wr - b_wr, 1);
    chk("post_tmo_data", data, 8'hE0);

    // FIFO full drops a good byte
    snap();
    wrfull = 1'b1;
    send_frame(8'h1C, 1'b0, 1'b1); cyc(4);
    chk("ovf_pulse", n_ovf - b_ovf, 1);
    chk("ovf_nowr", n_wr - b_wr, 0);
    chk("ovf_data", data, 8'hE0);
    chk("ovf_cnt", err_count, 4);
    wrfull = 1'b0;
    snap();
    send_frame(8'h5A, 1'b1, 1'b1); cyc(4);
    chk("post_ovf_wr", n_wr - b_wr, 1);
    chk("post_ovf_data", data, 8'h5A);

    // Reset mid-frame after 4 data bits of 0x5A (LSB first: 0,1,0,1)
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    clrn = 1'b0;
    #1;
    chk("mid_rst_data", data, 8'h00);
    chk("mid_rst_cnt", err_count, 8'h00);
    chk("mid_rst_pulses", {wrreq, parity_err, frame_err, overflow}, 4'b0000);
    cyc(3);
    clrn = 1'b1;
    cyc(5);
    snap();
    send_frame(8'h5A, 1'b1, 1'b1); cyc(4);
    chk("post_rst_wr", n_wr - b_wr, 1);
    chk("post_rst_data", data, 8'h5A);
    chk("post_rst_cnt", err_count, 0);

    // Saturation: 300 stop-bit errors into an 8-bit counter
    snap();
    for (int k = 0; k < 300; k++) send_frame(8'h00, 1'b1, 1'b0);
    cyc(4);
    chk("sat_pulses", n_frm - b_frm, 300);
    chk("sat_cnt", err_count, 8'hFF);

    chk("one_result_per_frame", n_multi, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_rx_frame.md
Name: ps2_rx_frame

Overview:
- PS/2 device-to-host receiver. Synchronises the raw ps2_clk/ps2_data lines and deserialises 11-bit frames: start, 8 data bits LSB first, odd parity, stop.
- Writes each good byte into the keyboard FIFO write port (data/wrreq/wrfull) in the clk domain.
- Sits directly upstream of the keyboard byte FIFO. Also flags parity, framing, timeout and overflow errors.

Parameters:
SYNC_STAGES, 3, synchroniser flops per PS/2 line (min 2)
TIMEOUT_CYCLES, 50000, max clk cycles between falling ps2_clk edges inside a frame (1 ms @ 50 MHz)
ERR_CNT_W, 8, width of saturating error counter

Ports:
clk  in  1  system clock; all logic on posedge clk
clrn  in  1  asynchronous active-low reset
ps2_clk  in  1  raw PS/2 clock line (asynchronous)
ps2_data  in  1  raw PS/2 data line (asynchronous)
wrfull  in  1  FIFO full flag; sampled in the cycle a byte would be written
data  out  8  received byte; holds last good byte
wrreq  out  1  one-cycle FIFO write strobe, coincident with new data
parity_err  out  1  one-cycle pulse: parity check failed
frame_err  out  1  one-cycle pulse: bad stop bit or inter-edge timeout
overflow  out  1  one-cycle pulse: good byte dropped because wrfull=1
err_count  out  ERR_CNT_W  saturating count of parity_err + frame_err + overflow events

Behaviour:
- Reset (clrn=0, async): state=IDLE; sync flops=1; bit_cnt, timer, shift reg, data, err_count=0; wrreq/parity_err/frame_err/overflow=0. Reset mid-frame discards the partial frame.
- Sync: each line passes through SYNC_STAGES flops.
  - fall = (prev stage==1 && last stage==0) on ps2_clk.
  - sampled data bit = last synchronised ps2_data stage in the same cycle.
- FSM (advances only on cycles where fall=1, except timeout):
  - IDLE: bit=0 -> DATA, bit_cnt=0, timer=0. bit=1 -> stay in IDLE, no error (glitch).
  - DATA: shift right, new bit enters MSB. After the 8th bit (bit_cnt==7) -> PARITY.
  - PARITY: latch parity bit -> STOP.
  - STOP: evaluate the frame, then -> IDLE unconditionally.
- Stop evaluation, on the cycle fall is seen in STOP; outputs register at the next posedge (1-cycle latency):
  - stop==0 -> frame_err pulse.
  - else if XOR(shreg, parity) != 1 -> parity_err pulse.
  - else if wrfull==1 -> overflow pulse; data unchanged.
  - else data<=shreg and wrreq=1 for exactly one cycle.
  - At most one of wrreq/parity_err/frame_err/overflow is asserted per frame.
- Timeout:
  - timer clears on every fall and while in IDLE; increments otherwise.
  - In DATA/PARITY/STOP with timer==TIMEOUT_CYCLES-1 and no fall: frame_err pulse, -> IDLE, bits discarded.
  - If fall and timeout coincide, fall wins.
- err_count increments by 1 on each error pulse and saturates at all-ones (no wrap).
- Back-to-back frames: a start bit arriving on the first fall after STOP is accepted (no idle gap required).
- Width rules: bit_cnt 3 bits; timer width = clog2(TIMEOUT_CYCLES).
- Host-to-device transmission is not supported; ps2 lines are input-only.

Decomposition:
- Shared package ps2_pkg:
  - state enum {IDLE, DATA, PARITY, STOP}
  - PS2_FRAME_BITS=11
  - PS2_DATA_BITS=8
- Sub-module ps2_sync_edge: SYNC_STAGES synchroniser for both lines plus the falling-edge detector. Outputs fall and data_s. Reused by the future mouse receiver.
- The FSM, timer and error logic stay in ps2_rx_frame.

Test Plan:
- Good frame 0x1C (bits 0,0,0,1,1,1,0,0,0,0,1; ~12 kHz ps2_clk) -> one wrreq pulse with data=0x1C; no error pulses; err_count=0.
- Back-to-back 0xF0 (parity 1) then 0x1C -> two wrreq pulses, data 0xF0 then 0x1C, no lost byte.
- 0x1C with parity=1 -> parity_err pulse, err_count=1, no wrreq, data keeps its previous value. Next, 0x1C with stop=0 -> frame_err, err_count=2.
- Stall after 5 bits for more than TIMEOUT_CYCLES (set to 100 in the bench) -> frame_err exactly at cycle 100 after the last fall. Then good 0xE0 (parity 0) -> wrreq, data=0xE0.
- wrfull=1 during a good 0x1C frame -> overflow pulse, no wrreq. Drop wrfull, send 0x5A (parity 1) -> wrreq, data=0x5A.
- clrn pulsed low after 4 data bits -> all outputs 0 immediately. Then a full 0x5A frame -> received correctly; err_count=0. Also force err_count saturation: 300 bad frames with ERR_CNT_W=8 -> err_count=255.
